pipe_adder: RTL
===============

Name: pipe_adder

Overview:
Parametrised, pipelined two-operand add/subtract unit. It is the next-generation replacement for the fixed 8-bit valid-only adder.
- Adds configurable operand width, pipeline depth and signedness.
- Adds a per-transaction add/subtract select.
- Adds full valid/ready backpressure with bubble collapsing, plus a completed-transaction counter.
- Sits between the stimulus side and the scoreboard side of the datapath.

Parameters:
DATA_W, 8, operand width in bits (2..32)
LATENCY, 2, register stages from input acceptance to output (1..4)
SIGNED, 0, 0 = operands unsigned, 1 = operands two's complement
CNT_W, 16, width of out_cnt

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_vld  input  1  input transaction valid
in_rdy  output  1  unit can accept input this cycle
addend0  input  DATA_W  operand A
addend1  input  DATA_W  operand B
sub  input  1  0: A+B, 1: A-B (sampled with operands)
out_vld  output  1  result valid
out_rdy  input  1  downstream accepts result
sum  output  DATA_W+1  exact result, two's complement when sub=1 or SIGNED=1
out_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Transfers:
  - Input transfer occurs when in_vld & in_rdy at a rising edge.
  - Output transfer occurs when out_vld & out_rdy at a rising edge.
- Pipeline structure: LATENCY stages S1..SL, each holding a valid bit plus payload. Stage SL drives out_vld and sum.
- Stage advance: stage k loads from stage k-1 (S1 loads from the inputs) when stage k is empty or stage k advances this cycle. SL advances when out_rdy=1.
- Ready: in_rdy = ~S1.vld | S1.advance. It is combinational from out_rdy through the stage chain. No input-to-output combinational path on data.
- Latency and throughput:
  - With no stall, a transaction accepted at edge t has out_vld=1 from edge t+LATENCY-1, i.e. visible LATENCY cycles after acceptance (LATENCY=1: visible the cycle after acceptance).
  - Sustained throughput is 1 transaction per cycle.
- Bubbles: a bubble (empty stage) is collapsed when the stage downstream of it is stalled, so an upstream stage can still load.
- Stall: while out_vld=1 and out_rdy=0, sum and out_vld hold stable. Upstream stages fill and in_rdy drops once all LATENCY stages are full.
- Arithmetic:
  - Operands are extended to DATA_W+1 bits: zero-extend if SIGNED=0, sign-extend if SIGNED=1.
  - Result is A+B or A-B in DATA_W+1 bits. It is always exact, no overflow possible.
  - Unsigned subtract with A<B yields a negative two's-complement value.
  - The operation may be computed in S1. Later stages only delay it.
- Ordering: results leave strictly in acceptance order. Nothing is dropped or duplicated.
- out_cnt: increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset:
  - While rst=1, all stage valid bits clear, out_vld=0, sum=0, out_cnt=0 and in_rdy=0. Inputs are ignored.
  - Reset mid-operation discards all in-flight transactions. The first cycle after rst deasserts has in_rdy=1 and out_vld=0.
- Simultaneous events: acceptance at S1 and output at SL in the same edge are both honoured, and out_cnt still increments.
- Boundary: in_vld high with in_rdy low is not a transfer. Operands may change freely.

Test Plan:
- Latency: DATA_W=8, LATENCY=2, out_rdy=1; accept A=200,B=100,sub=0 at edge t -> out_vld=1 from edge t+1, sum=300 (9'h12C), out_cnt=1 after the transfer.
- Subtract and signedness:
  - SIGNED=0: A=5, B=10, sub=1 -> sum=9'h1FB (-5).
  - SIGNED=1: A=8'h80, B=8'h80, sub=0 -> sum=9'h100 (-256).
  - SIGNED=1: A=8'h7F, B=8'h80, sub=1 -> sum=9'h0FF (255).
- Backpressure: stream 8 transactions back-to-back with out_rdy=0 for 5 cycles -> in_rdy falls after LATENCY accepts, sum/out_vld stable throughout the stall, then all 8 results emerge in order with none lost and out_cnt=8.
- Bubble collapse: LATENCY=3; one transaction, then in_vld=0 for one cycle, then a second, with out_rdy=0 -> both stages load, in_rdy stays 1 until 3 transactions are held.
- Reset mid-stream: assert rst for 1 cycle with 3 transactions in flight -> out_vld=0 and out_cnt=0 next cycle, no stale results ever appear, in_rdy=1 on the first cycle after rst.
- Counter wrap: CNT_W=4; 17 output transfers -> out_cnt reads 15 after 15 transfers, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: input-side valid/ready with operands, output-side valid/ready with result.
interface pipe_adder_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] addend0;
  logic [DATA_W-1:0] addend1;
  logic              sub;
  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output in_vld, addend0, addend1, sub, out_rdy,
    input  in_rdy, out_vld, sum, out_cnt
  );

  modport slave (
    input  in_vld, addend0, addend1, sub, out_rdy,
    output in_rdy, out_vld, sum, out_cnt
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with valid/ready backpressure, bubble collapsing and a transfer counter.
module pipe_adder #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2,
  parameter int SIGNED  = 0,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_adder_if.slave   bus
);
  localparam logic SGN = (SIGNED != 0);

  logic [LATENCY-1:0] vld;
  logic [DATA_W:0]    data [LATENCY];
  logic [LATENCY-1:0] load;
  logic [CNT_W-1:0]   cnt;
  logic               full_tail;
  logic [DATA_W:0]    a_ext;
  logic [DATA_W:0]    b_ext;
  logic [DATA_W:0]    result;

  // A stage may load when the output drains or any stage from it downward is empty,
  // which is the closed form of the ripple "empty or advancing" condition.
  always_comb begin
    load      = '0;
    full_tail = 1'b1;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      full_tail                = full_tail & vld[LATENCY-1-i];
      load[LATENCY-1-i]        = bus.out_rdy | ~full_tail;
    end
  end

  always_comb begin
    a_ext  = {SGN & bus.addend0[DATA_W-1], bus.addend0};
    b_ext  = {SGN & bus.addend1[DATA_W-1], bus.addend1};
    result = bus.sub ? (a_ext - b_ext) : (a_ext + b_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld[0]  <= bus.in_vld;
        data[0] <= result;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        if (load[i]) begin
          vld[i]  <= vld[i-1];
          data[i] <= data[i-1];
        end
      end
      if (vld[LATENCY-1] && bus.out_rdy) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.in_rdy  = ~rst & load[0];
    bus.out_vld = ~rst & vld[LATENCY-1];
    bus.sum     = data[LATENCY-1];
    bus.out_cnt = cnt;
  end
endmodule
